// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   bcd_state_t     : converter FSM states
//   BCD_DIGIT_W     : bits per BCD digit
//   bcd_min_digits  : digit count needed to show any WIDTH-bit value without overflow
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } bcd_state_t;

  localparam int unsigned BCD_DIGIT_W = 4;

  // Smallest D with 10^D > 2^width - 1; intended for parents sizing DIGITS.
  function automatic int unsigned bcd_min_digits(input int unsigned width);
    longint unsigned max_val;
    longint unsigned lim;
    int unsigned     d;
    max_val = (64'd1 << width) - 64'd1;
    d       = 1;
    lim     = 64'd10;
    while (lim <= max_val) begin
      d   = d + 1;
      lim = lim * 64'd10;
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more so
// the following left shift carries correctly into the next decimal place.
//   digit : current scratch digit
//   adj_c : corrected digit (combinational, 4-bit wrap, no carry out)
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BCD_DIGIT_W-1:0] adj_c
);

  always_comb begin
    adj_c = digit;
    if (digit >= BCD_DIGIT_W'(5)) begin
      adj_c = digit + BCD_DIGIT_W'(3);
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one input bit per clock.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   start    : request a conversion (taken only while idle)
//   bin      : WIDTH-bit unsigned value, sampled when start is taken
//   busy     : conversion in progress, including the done cycle
//   done     : one-cycle pulse when bcd/ovf update
//   bcd      : DIGITS packed BCD digits, ones digit in [3:0]
//   ovf      : value did not fit in DIGITS digits; bcd is zero then
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [WIDTH-1:0]              bin,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
  output logic                          ovf
);

  localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  // Parameter range checks at elaboration
  if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
    $error("bin2bcd_seq: WIDTH=%0d outside 4..32", WIDTH);
  end
  if (DIGITS < 1 || DIGITS > 10) begin : g_bad_digits
    $error("bin2bcd_seq: DIGITS=%0d outside 1..10", DIGITS);
  end

  bcd_state_t       state, state_next;
  logic [WIDTH-1:0] shreg, shreg_next;
  logic [BCD_W-1:0] scratch, scratch_next, scratch_adj;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             sticky, sticky_next;
  logic [BCD_W-1:0] bcd_next;
  logic             ovf_next, busy_next, done_next;

  // Per-digit add-3 correction ahead of each shift
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit (scratch[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .adj_c (scratch_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      scratch <= '0;
      cnt     <= '0;
      sticky  <= 1'b0;
      bcd     <= '0;
      ovf     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_next;
      shreg   <= shreg_next;
      scratch <= scratch_next;
      cnt     <= cnt_next;
      sticky  <= sticky_next;
      bcd     <= bcd_next;
      ovf     <= ovf_next;
      busy    <= busy_next;
      done    <= done_next;
    end
  end

  // Next-state and datapath update; result registers load on the final shift
  // so bcd/ovf are already valid while done is high.
  always_comb begin
    state_next   = state;
    shreg_next   = shreg;
    scratch_next = scratch;
    cnt_next     = cnt;
    sticky_next  = sticky;
    bcd_next     = bcd;
    ovf_next     = ovf;
    done_next    = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          shreg_next   = bin;
          scratch_next = '0;
          cnt_next     = '0;
          sticky_next  = 1'b0;
          state_next   = SHIFT;
        end
      end
      SHIFT: begin
        {scratch_next, shreg_next} = {scratch_adj[BCD_W-2:0], shreg, 1'b0};
        // A one leaving the top digit means the value needs more digits
        sticky_next = sticky | scratch_adj[BCD_W-1];
        cnt_next    = cnt + CNT_W'(1);
        if (cnt == CNT_W'(WIDTH - 1)) begin
          state_next = DONE;
          done_next  = 1'b1;
          ovf_next   = sticky_next;
          bcd_next   = sticky_next ? '0 : scratch_next;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq in three configurations:
// a = WIDTH 8 / DIGITS 3, b = WIDTH 16 / DIGITS 5, c = WIDTH 8 / DIGITS 2.
module tb_bin2bcd_seq;

  logic clk;
  logic rst;

  logic        start_a, busy_a, done_a, ovf_a;
  logic [7:0]  bin_a;
  logic [11:0] bcd_a;

  logic        start_b, busy_b, done_b, ovf_b;
  logic [15:0] bin_b;
  logic [19:0] bcd_b;

  logic        start_c, busy_c, done_c, ovf_c;
  logic [7:0]  bin_c;
  logic [7:0]  bcd_c;

  int errors = 0;
  int checks = 0;

  bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .bin(bin_a),
    .busy(busy_a), .done(done_a), .bcd(bcd_a), .ovf(ovf_a)
  );

  bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .bin(bin_b),
    .busy(busy_b), .done(done_b), .bcd(bcd_b), .ovf(ovf_b)
  );

  bin2bcd_seq #(.WIDTH(8), .DIGITS(2)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .bin(bin_c),
    .busy(busy_c), .done(done_c), .bcd(bcd_c), .ovf(ovf_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_done(input int which);
    case (which)
      0:       return done_a;
      1:       return done_b;
      default: return done_c;
    endcase
  endfunction

  function automatic logic get_busy(input int which);
    case (which)
      0:       return busy_a;
      1:       return busy_b;
      default: return busy_c;
    endcase
  endfunction

  function automatic logic [31:0] get_bcd(input int which);
    case (which)
      0:       return 32'(bcd_a);
      1:       return 32'(bcd_b);
      default: return 32'(bcd_c);
    endcase
  endfunction

  function automatic logic get_ovf(input int which);
    case (which)
      0:       return ovf_a;
      1:       return ovf_b;
      default: return ovf_c;
    endcase
  endfunction

  // Decimal reference: digit i of v placed at bits [4i+3:4i]
  function automatic logic [31:0] ref_bcd(input int unsigned v, input int digits);
    logic [31:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < digits; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Pulse start for one edge, then wait (bounded) for done.
  // lat counts edges from acceptance up to the done sample; bsy counts busy samples.
  task automatic convert(input int which, input logic [31:0] v, output int lat, output int bsy);
    case (which)
      0:       begin start_a = 1'b1; bin_a = 8'(v);  end
      1:       begin start_b = 1'b1; bin_b = 16'(v); end
      default: begin start_c = 1'b1; bin_c = 8'(v);  end
    endcase
    step();
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
    lat = 1;
    bsy = get_busy(which) ? 1 : 0;
    while (!get_done(which) && lat < 60) begin
      step();
      lat++;
      if (get_busy(which)) bsy++;
    end
    chk("done_seen", 32'(get_done(which)), 32'd1);
  endtask

  initial begin
    int  lat;
    int  bsy;
    bit  seen;

    rst     = 1'b1;
    start_a = 1'b0; bin_a = '0;
    start_b = 1'b0; bin_b = '0;
    start_c = 1'b0; bin_c = '0;
    step();
    step();

    // Reset state
    chk("rst_busy_a", 32'(busy_a), 32'd0);
    chk("rst_done_a", 32'(done_a), 32'd0);
    chk("rst_bcd_a",  32'(bcd_a),  32'd0);
    chk("rst_ovf_a",  32'(ovf_a),  32'd0);
    chk("rst_busy_b", 32'(busy_b), 32'd0);
    chk("rst_bcd_c",  32'(bcd_c),  32'd0);

    // 255 with start in the very first cycle after reset release
    rst = 1'b0;
    convert(0, 32'd255, lat, bsy);
    chk("a255_lat",  32'(lat), 32'd9);
    chk("a255_busy", 32'(bsy), 32'd9);
    chk("a255_bcd",  32'(bcd_a), 32'h255);
    chk("a255_ovf",  32'(ovf_a), 32'd0);
    step();
    chk("a255_idle_busy", 32'(busy_a), 32'd0);
    chk("a255_done_pulse", 32'(done_a), 32'd0);
    step();
    step();
    chk("a255_hold_bcd", 32'(bcd_a), 32'h255);

    // Exhaustive 8-bit sweep against the decimal reference
    for (int v = 0; v < 256; v++) begin
      convert(0, 32'(v), lat, bsy);
      chk("a_sweep_bcd", get_bcd(0), ref_bcd(v, 3));
      chk("a_sweep_ovf", 32'(get_ovf(0)), 32'd0);
      step();
    end
    convert(0, 32'd0, lat, bsy);
    chk("a0_bcd", 32'(bcd_a), 32'h000);
    step();

    // 16-bit / 5 digits
    convert(1, 32'd65535, lat, bsy);
    chk("b65535_lat", 32'(lat), 32'd17);
    chk("b65535_bcd", 32'(bcd_b), 32'h65535);
    chk("b65535_ovf", 32'(ovf_b), 32'd0);
    step();
    convert(1, 32'd10000, lat, bsy);
    chk("b10000_bcd", 32'(bcd_b), 32'h10000);
    step();

    // 8-bit / 2 digits: overflow boundary, then recovery
    convert(2, 32'd99, lat, bsy);
    chk("c99_bcd", 32'(bcd_c), 32'h99);
    chk("c99_ovf", 32'(ovf_c), 32'd0);
    step();
    convert(2, 32'd100, lat, bsy);
    chk("c100_bcd", 32'(bcd_c), 32'h00);
    chk("c100_ovf", 32'(ovf_c), 32'd1);
    step();
    step();
    chk("c100_hold_ovf", 32'(ovf_c), 32'd1);
    convert(2, 32'd255, lat, bsy);
    chk("c255_ovf", 32'(ovf_c), 32'd1);
    step();
    convert(2, 32'd42, lat, bsy);
    chk("c42_bcd", 32'(bcd_c), 32'h42);
    chk("c42_ovf", 32'(ovf_c), 32'd0);
    step();

    // Handshake: start mid-SHIFT and in the DONE cycle is ignored; bin change has no effect
    start_a = 1'b1; bin_a = 8'd7;
    step();                       // accepted
    start_a = 1'b0; bin_a = 8'd200;
    step(); step(); step();
    start_a = 1'b1;
    step();                       // mid-SHIFT request
    start_a = 1'b0;
    step(); step(); step(); step();
    chk("hs_done", 32'(done_a), 32'd1);
    chk("hs_bcd",  32'(bcd_a), 32'h007);
    start_a = 1'b1;
    step();                       // request during the DONE cycle
    start_a = 1'b0;
    chk("hs_busy_after", 32'(busy_a), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done_a || busy_a) seen = 1'b1;
    end
    chk("hs_not_queued", 32'(seen), 32'd0);
    chk("hs_bcd_hold", 32'(bcd_a), 32'h007);
    convert(0, 32'd200, lat, bsy);
    chk("hs200_bcd", 32'(bcd_a), 32'h200);
    step();

    // Reset abort after four shifts
    start_a = 1'b1; bin_a = 8'd123;
    step();                       // accepted
    start_a = 1'b0;
    step(); step(); step(); step();
    chk("ab_busy_pre", 32'(busy_a), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("ab_busy", 32'(busy_a), 32'd0);
    chk("ab_bcd",  32'(bcd_a), 32'd0);
    chk("ab_ovf",  32'(ovf_a), 32'd0);
    chk("ab_done", 32'(done_a), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done_a) seen = 1'b1;
    end
    chk("ab_no_done", 32'(seen), 32'd0);
    convert(0, 32'd45, lat, bsy);
    chk("ab45_bcd", 32'(bcd_a), 32'h045);
    chk("ab45_lat", 32'(lat), 32'd9);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
